// File: rtl/fft16_sched_pkg.sv
// ============================================================================
// fft_pkg : shared constants, FSM state type and bit-reversal helper for
//           the 16-point FFT scheduler.                         Rev 1.0
// ============================================================================
`default_nettype none

package fft_pkg;

    localparam int FFT_N           = 16;
    localparam int FFT_LOG2N       = 4;
    localparam int TIMEOUT_DEFAULT = 15;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_UNLOAD = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

    function automatic logic [3:0] bitrev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fft16_sched_addr_gen.sv
// ============================================================================
// fft16_addr_gen : maps (stage, butterfly) to in-place DIF operand indices
//                  and twiddle exponent.                        Rev 1.0
// ============================================================================
`default_nettype none

module fft16_addr_gen (
    input  logic [1:0] stage,
    input  logic [2:0] bfly,
    output logic [3:0] idx_a,
    output logic [3:0] idx_b,
    output logic [2:0] power
);

    // The span bit (8>>s) is spliced into k at position 3-s; k's bits below
    // it are j, the bits above it are the group number g.
    always_comb begin
        idx_a = 4'd0;
        idx_b = 4'd0;
        power = 3'd0;
        case (stage)
            2'd0: begin
                idx_a = {1'b0, bfly};
                idx_b = {1'b1, bfly};
                power = bfly;
            end
            2'd1: begin
                idx_a = {bfly[2], 1'b0, bfly[1:0]};
                idx_b = {bfly[2], 1'b1, bfly[1:0]};
                power = {bfly[1:0], 1'b0};
            end
            2'd2: begin
                idx_a = {bfly[2:1], 1'b0, bfly[0]};
                idx_b = {bfly[2:1], 1'b1, bfly[0]};
                power = {bfly[0], 2'b00};
            end
            default: begin
                idx_a = {bfly, 1'b0};
                idx_b = {bfly, 1'b1};
                power = 3'd0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/fft16_sched.sv
// ============================================================================
// fft16_sched : frame buffer and sequencer driving 32 DIF butterflies
//               through a single radix-2 PE, natural-order output. Rev 1.0
// ============================================================================
`default_nettype none

module fft16_sched
    import fft_pkg::*;
#(
    parameter int DW      = 16,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [2*DW-1:0] in_data,
    output logic            in_ready,
    output logic [2*DW-1:0] pe_a,
    output logic [2*DW-1:0] pe_b,
    output logic [2:0]      pe_power,
    output logic            pe_valid,
    input  logic [2*DW-1:0] pe_fft_a,
    input  logic [2*DW-1:0] pe_fft_b,
    input  logic            pe_done,
    output logic            out_valid,
    output logic [2*DW-1:0] out_data,
    input  logic            out_ready,
    output logic            busy,
    output logic            err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t          r_state;
    state_t          w_next;
    logic [2*DW-1:0] r_buf [FFT_N];
    logic [3:0]      r_n;
    logic [3:0]      r_m;
    logic [1:0]      r_s;
    logic [2:0]      r_k;
    logic [CW-1:0]   r_cnt;
    logic            r_err;
    logic [2*DW-1:0] r_pe_a;
    logic [2*DW-1:0] r_pe_b;
    logic [2:0]      r_pe_power;

    logic [3:0]      w_idx_a;
    logic [3:0]      w_idx_b;
    logic [2:0]      w_power;
    logic            w_last_bfly;
    logic            w_timeout;

    fft16_addr_gen u_addr_gen (
        .stage (r_s),
        .bfly  (r_k),
        .idx_a (w_idx_a),
        .idx_b (w_idx_b),
        .power (w_power)
    );

    assign w_last_bfly = (r_s == 2'd3) && (r_k == 3'd7);
    assign w_timeout   = (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        pe_valid  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        pe_a      = r_pe_a;
        pe_b      = r_pe_b;
        pe_power  = r_pe_power;
        out_data  = '0;
        case (r_state)
            ST_IDLE: begin
                busy   = 1'b0;
                w_next = ST_LOAD;
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (r_n == 4'd15)) w_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                pe_valid = 1'b1;
                pe_a     = r_buf[w_idx_a];
                pe_b     = r_buf[w_idx_b];
                pe_power = w_power;
                w_next   = ST_WAIT;
            end
            ST_WAIT: begin
                if (pe_done)        w_next = w_last_bfly ? ST_UNLOAD : ST_ISSUE;
                else if (w_timeout) w_next = ST_ERR;
            end
            ST_UNLOAD: begin
                out_valid = 1'b1;
                out_data  = r_buf[bitrev4(r_m)];
                if (out_ready && (r_m == 4'd15)) w_next = ST_LOAD;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Counters and operand holds; n, m, s, k all wrap to 0 at frame end.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_n        <= 4'd0;
            r_m        <= 4'd0;
            r_s        <= 2'd0;
            r_k        <= 3'd0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_pe_a     <= '0;
            r_pe_b     <= '0;
            r_pe_power <= 3'd0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (in_valid) r_n <= r_n + 4'd1;
                end
                ST_ISSUE: begin
                    r_cnt      <= '0;
                    r_pe_a     <= r_buf[w_idx_a];
                    r_pe_b     <= r_buf[w_idx_b];
                    r_pe_power <= w_power;
                end
                ST_WAIT: begin
                    if (pe_done) begin
                        r_k <= r_k + 3'd1;
                        if (r_k == 3'd7) r_s <= r_s + 2'd1;
                        if (w_last_bfly) r_m <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                        if (w_timeout) r_err <= 1'b1;
                    end
                end
                ST_UNLOAD: begin
                    if (out_ready) r_m <= r_m + 4'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_LOAD && in_valid) begin
            r_buf[r_n] <= in_data;
        end else if (r_state == ST_WAIT && pe_done) begin
            r_buf[w_idx_a] <= pe_fft_a;
            r_buf[w_idx_b] <= pe_fft_b;
        end
    end

    assign err = r_err;

endmodule

`default_nettype wire

// File: tb/tb_fft16_sched.sv
// ============================================================================
// tb_fft16_sched : directed bench for fft16_sched with a behavioural PE.
//                                                               Rev 1.0
// ============================================================================
`default_nettype none

module tb_fft16_sched;

    localparam int DW = 16;
    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic [31:0] pe_a, pe_b;
    logic [2:0]  pe_power;
    logic        pe_valid;
    logic [31:0] pe_fft_a = '0;
    logic [31:0] pe_fft_b = '0;
    logic        pe_done = 1'b0;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    fft16_sched #(.DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .pe_a(pe_a), .pe_b(pe_b), .pe_power(pe_power),
        .pe_valid(pe_valid), .pe_fft_a(pe_fft_a), .pe_fft_b(pe_fft_b),
        .pe_done(pe_done), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .busy(busy), .err(err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // PE model: mode 0 never answers, 1 echoes operands, 2 ideal butterfly
    int          pe_mode = 1;
    int          pe_lat  = 1;
    bit          inject  = 0;
    int          pe_cnt  = 0;
    int          strobes = 0;
    bit          overlap = 0;
    logic [31:0] ca, cb;
    logic [2:0]  cp;
    logic [31:0] log_a [32];
    logic [31:0] log_b [32];
    logic [2:0]  log_p [32];

    function automatic logic [31:0] twid(input logic [31:0] d, input logic [2:0] p);
        int c, s, x, y, re, im;
        case (p)
            3'd0: begin c = 16384;  s = 0;     end
            3'd1: begin c = 15137;  s = 6270;  end
            3'd2: begin c = 11585;  s = 11585; end
            3'd3: begin c = 6270;   s = 15137; end
            3'd4: begin c = 0;      s = 16384; end
            3'd5: begin c = -6270;  s = 15137; end
            3'd6: begin c = -11585; s = 11585; end
            default: begin c = -15137; s = 6270; end
        endcase
        x  = $signed(d[31:16]);
        y  = $signed(d[15:0]);
        re = (x * c + y * s + 8192) >>> 14;
        im = (y * c - x * s + 8192) >>> 14;
        return {re[15:0], im[15:0]};
    endfunction

    always @(posedge clk) begin
        #1;
        pe_done = 1'b0;
        if (in_ready && out_valid) overlap = 1'b1;
        if (pe_cnt > 0) begin
            pe_cnt = pe_cnt - 1;
            if (pe_cnt == 0) begin
                pe_done = 1'b1;
                if (pe_mode == 1) begin
                    pe_fft_a = ca;
                    pe_fft_b = cb;
                end else begin
                    pe_fft_a = {ca[31:16] + cb[31:16], ca[15:0] + cb[15:0]};
                    pe_fft_b = twid({ca[31:16] - cb[31:16], ca[15:0] - cb[15:0]}, cp);
                end
            end
        end
        if (pe_valid) begin
            if (strobes < 32) begin
                log_a[strobes] = pe_a;
                log_b[strobes] = pe_b;
                log_p[strobes] = pe_power;
            end
            strobes = strobes + 1;
            if (pe_mode != 0) begin
                ca = pe_a; cb = pe_b; cp = pe_power;
                pe_cnt = pe_lat;
            end
            if (inject) begin
                pe_done = 1'b1; pe_fft_a = 32'hDEAD_BEEF; pe_fft_b = 32'hBAD0_BAD0;
            end
        end else if (inject && !pe_done && (in_ready || out_valid) && $urandom_range(0, 3) == 0) begin
            pe_done = 1'b1; pe_fft_a = 32'h1234_5678; pe_fft_b = 32'h8765_4321;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_frame(input logic [31:0] x [16], input bit gaps);
        int i = 0;
        int g = 0;
        while (i < 16 && g < 300) begin
            @(negedge clk);
            g++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = x[i];
            end
            if (in_valid && in_ready) i++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("load_accepted", i, 16);
    endtask

    task automatic wait_out(output int ncyc);
        int t0 = -1;
        int g  = 0;
        while (!out_valid && g < 3000) begin
            if (pe_valid && t0 < 0) t0 = cyc;
            @(negedge clk);
            g++;
        end
        chk("out_valid_seen", 32'(out_valid), 1);
        ncyc = (t0 < 0) ? -1 : cyc - t0;
    endtask

    task automatic unload(input bit bp, output logic [31:0] got [16]);
        int m = 0;
        int g = 0;
        bit stalled = 0;
        bit early = 0;
        logic [31:0] prev = '0;
        while (m < 16 && g < 400) begin
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled && out_valid) chk("stall_stable", out_data, prev);
            if (in_ready) early = 1'b1;
            if (out_valid && out_ready) begin
                got[m]  = out_data;
                m++;
                stalled = 1'b0;
            end else begin
                stalled = out_valid;
                prev    = out_data;
            end
            @(negedge clk);
            g++;
        end
        chk("bins_accepted", m, 16);
        chk("in_ready_early", 32'(early), 0);
        chk("post_out_valid", 32'(out_valid), 0);
        chk("post_in_ready", 32'(in_ready), 1);
    endtask

    task automatic do_frame(input string nm, input logic [31:0] x [16], input logic [31:0] e [16],
                            input int mode, input int lat, input bit gaps, input bit inj, input bit bp);
        logic [31:0] got [16];
        int nc;
        int g = 0;
        pe_mode = mode;
        pe_lat  = lat;
        strobes = 0;
        while (!in_ready && g < 50) begin @(negedge clk); g++; end
        inject = inj;
        load_frame(x, gaps);
        wait_out(nc);
        chk({nm, "_compute_cycles"}, nc, 32 * (lat + 1));
        unload(bp, got);
        inject = 0;
        for (int i = 0; i < 16; i++) chk($sformatf("%s_bin%0d", nm, i), got[i], e[i]);
        chk({nm, "_strobes"}, strobes, 32);
        chk({nm, "_err"}, 32'(err), 0);
    endtask

    logic [31:0] xv [16];
    logic [31:0] ev [16];
    int ea [32] = '{0,1,2,3,4,5,6,7, 0,1,2,3,8,9,10,11, 0,1,4,5,8,9,12,13, 0,2,4,6,8,10,12,14};
    int eb [32] = '{8,9,10,11,12,13,14,15, 4,5,6,7,12,13,14,15, 2,3,6,7,10,11,14,15, 1,3,5,7,9,11,13,15};
    int ep [32] = '{0,1,2,3,4,5,6,7, 0,2,4,6,0,2,4,6, 0,4,0,4,0,4,0,4, 0,0,0,0,0,0,0,0};
    int br [16] = '{0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15};

    initial begin
        // reset held with random inputs
        repeat (3) begin
            @(negedge clk);
            in_valid  = 1'($urandom);
            in_data   = $urandom;
            out_ready = 1'($urandom);
        end
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_pe_valid", 32'(pe_valid), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_pe_a", pe_a, 0);
        chk("rst_pe_b", pe_b, 0);
        chk("rst_pe_power", 32'(pe_power), 0);
        chk("rst_out_data", out_data, 0);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("release_in_ready", 32'(in_ready), 1);

        // address sequence: echo PE keeps the buffer intact, so operands reveal indices
        for (int i = 0; i < 16; i++) begin
            xv[i] = {16'(i), 16'(i + 256)};
            ev[i] = {16'(br[i]), 16'(br[i] + 256)};
        end
        do_frame("addr", xv, ev, 1, 1, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("idx_a_%0d", i), 32'(log_a[i][31:16]), ea[i]);
            chk($sformatf("idx_b_%0d", i), 32'(log_b[i][31:16]), eb[i]);
            chk($sformatf("power_%0d", i), 32'(log_p[i]), ep[i]);
        end

        // impulse, ideal PE, L=2
        for (int i = 0; i < 16; i++) begin xv[i] = '0; ev[i] = 32'h0100_0000; end
        xv[0] = 32'h0100_0000;
        do_frame("impulse", xv, ev, 2, 2, 0, 0, 0);

        // constant frame, random L, gaps, spurious pe_done, backpressure
        for (int i = 0; i < 16; i++) begin xv[i] = 32'h0010_0020; ev[i] = '0; end
        ev[0] = 32'h0100_0200;
        do_frame("const", xv, ev, 2, $urandom_range(1, 5), 1, 1, 1);

        // alternating-sign frame: all energy in bin 8
        for (int i = 0; i < 16; i++) begin
            xv[i] = (i % 2 == 0) ? 32'h0001_0002 : 32'hFFFF_FFFE;
            ev[i] = '0;
        end
        ev[8] = 32'h0010_0020;
        do_frame("alt", xv, ev, 2, $urandom_range(1, 5), 1, 1, 1);

        // pe_done on the final allowed WAIT cycle still completes
        for (int i = 0; i < 16; i++) begin
            xv[i] = {16'(i), 16'(i + 256)};
            ev[i] = {16'(br[i]), 16'(br[i] + 256)};
        end
        do_frame("lat15", xv, ev, 1, TO, 0, 0, 0);

        // reset mid-compute, late pe_done must be ignored
        pe_mode = 2; pe_lat = 5;
        for (int i = 0; i < 16; i++) xv[i] = 32'h0100_0000 >> (i == 0 ? 0 : 31);
        load_frame(xv, 0);
        repeat (20) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_pe_valid", 32'(pe_valid), 0);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin xv[i] = '0; ev[i] = 32'h0100_0000; end
        xv[0] = 32'h0100_0000;
        do_frame("post_midrst", xv, ev, 2, 3, 0, 0, 0);

        // timeout: PE never answers
        pe_mode = 0;
        load_frame(xv, 0);
        chk("to_first_issue", 32'(pe_valid), 1);
        repeat (TO) @(negedge clk);
        chk("to_err_before", 32'(err), 0);
        chk("to_busy_before", 32'(busy), 1);
        @(negedge clk);
        chk("to_err", 32'(err), 1);
        chk("to_busy", 32'(busy), 0);
        strobes = 0;
        repeat (20) @(negedge clk);
        chk("to_no_strobes", strobes, 0);
        chk("to_err_sticky", 32'(err), 1);
        rst = 1'b0;
        @(negedge clk);
        chk("to_rst_clears_err", 32'(err), 0);
        rst = 1'b1;
        do_frame("post_to", xv, ev, 2, 1, 1, 0, 1);

        chk("no_ready_valid_overlap", 32'(overlap), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
